// File: rtl/ste_dma_snd_ctrl.sv
// -----------------------------------------------------------------------------
// ste_dma_snd_ctrl
//
// STE sound DMA frame controller. It holds the frame start, end and counter
// registers. It wins bus slots for sound fetches while the shifter FIFO has
// room. For each fetch it presents the word address and holds SLOAD_N low, so
// the shifter latches MDIN. A one-cycle sint pulse marks each frame end.
// Playback is either single-shot or looped.
//
// Ports
//   clk32     system clock
//   reset     asynchronous, active-high reset
//   cs        register window select
//   rw        1 = CPU read, 0 = CPU write
//   a         word register index (A[5:1])
//   din       CPU write data
//   dout      CPU read data (combinational, 0 unless cs & rw)
//   slot      one-cycle pulse: bus slot available for sound DMA
//   sreq      shifter FIFO not full
//   sload_n   shifter load strobe, low for SLOAD_LEN cycles per fetch
//   sdma_act  high while a fetch owns the bus
//   saddr     word address [23:1] of the current fetch
//   sactive   playback enabled (control bit 0)
//   sint      one-cycle pulse at each frame end
// -----------------------------------------------------------------------------
module ste_dma_snd_ctrl #(
    parameter int unsigned SLOAD_LEN = 4
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        cs,
    input  logic        rw,
    input  logic [4:0]  a,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        slot,
    input  logic        sreq,
    output logic        sload_n,
    output logic        sdma_act,
    output logic [22:0] saddr,
    output logic        sactive,
    output logic        sint
);

    localparam logic [3:0] LastLen = 4'(SLOAD_LEN - 1);

    typedef enum logic [1:0] {StIdle, StArm, StWait, StLoad} state_e;

    state_e      state_q, state_d;
    logic [22:0] start_q, start_d, end_q, end_d;
    logic [22:0] start_l_q, start_l_d, end_l_q, end_l_d;
    logic [22:0] cnt_q, cnt_d;
    logic        en_q, en_d, loop_q, loop_d;
    logic [3:0]  len_q, len_d;
    logic        sload_n_q, sload_n_d, sdma_act_q, sdma_act_d;
    logic        frame_end;
    logic        wr;

    // Only the low byte carries register data.
    logic unused_din;
    assign unused_din = ^din[15:8];

    assign wr = cs & ~rw;

    // Address registers are split hi/mid/lo; lo holds A[7:1] with bit 0 reading 0.
    function automatic logic [15:0] addr_field(input logic [22:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    return {8'h00, w[22:15]};
            2'd1:    return {8'h00, w[14:7]};
            default: return {8'h00, w[6:0], 1'b0};
        endcase
    endfunction

    always_comb begin
        dout = '0;
        if (cs && rw) begin
            case (a)
                5'd0:    dout = {14'b0, loop_q, en_q};
                5'd1:    dout = addr_field(start_q, 2'd0);
                5'd2:    dout = addr_field(start_q, 2'd1);
                5'd3:    dout = addr_field(start_q, 2'd2);
                5'd4:    dout = addr_field(cnt_q, 2'd0);
                5'd5:    dout = addr_field(cnt_q, 2'd1);
                5'd6:    dout = addr_field(cnt_q, 2'd2);
                5'd7:    dout = addr_field(end_q, 2'd0);
                5'd8:    dout = addr_field(end_q, 2'd1);
                5'd9:    dout = addr_field(end_q, 2'd2);
                default: dout = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        start_l_d  = start_l_q;
        end_l_d    = end_l_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        loop_d     = loop_q;
        len_d      = len_q;
        sload_n_d  = sload_n_q;
        sdma_act_d = sdma_act_q;
        frame_end  = 1'b0;

        case (state_q)
            StIdle: begin
                if (en_q) state_d = StArm;
            end
            StArm: begin
                start_l_d = start_q;
                end_l_d   = end_q;
                cnt_d     = start_q;
                state_d   = StWait;
            end
            StWait: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (cnt_q == end_l_q) begin
                    frame_end = 1'b1;
                    if (loop_q) begin
                        start_l_d = start_q;
                        end_l_d   = end_q;
                        cnt_d     = start_q;
                    end else begin
                        en_d    = 1'b0;
                        state_d = StIdle;
                    end
                end else if (slot && sreq) begin
                    state_d    = StLoad;
                    sload_n_d  = 1'b0;
                    sdma_act_d = 1'b1;
                    len_d      = '0;
                end
            end
            StLoad: begin
                // A fetch always runs to completion; en is only checked back in WAIT.
                if (len_q == LastLen) begin
                    sload_n_d  = 1'b1;
                    sdma_act_d = 1'b0;
                    cnt_d      = cnt_q + 23'd1;
                    state_d    = StWait;
                end else begin
                    len_d = len_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // CPU writes come last so a control write overrides the FSM's en/loop update.
        if (wr) begin
            case (a)
                5'd0: begin
                    en_d   = din[0];
                    loop_d = din[1];
                end
                5'd1:    start_d[22:15] = din[7:0];
                5'd2:    start_d[14:7]  = din[7:0];
                5'd3:    start_d[6:0]   = din[7:1];
                5'd7:    end_d[22:15]   = din[7:0];
                5'd8:    end_d[14:7]    = din[7:0];
                5'd9:    end_d[6:0]     = din[7:1];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            start_q    <= '0;
            end_q      <= '0;
            start_l_q  <= '0;
            end_l_q    <= '0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            loop_q     <= 1'b0;
            len_q      <= '0;
            sload_n_q  <= 1'b1;
            sdma_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            end_q      <= end_d;
            start_l_q  <= start_l_d;
            end_l_q    <= end_l_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            loop_q     <= loop_d;
            len_q      <= len_d;
            sload_n_q  <= sload_n_d;
            sdma_act_q <= sdma_act_d;
        end
    end

    assign sload_n  = sload_n_q;
    assign sdma_act = sdma_act_q;
    assign saddr    = cnt_q;
    assign sactive  = en_q;
    assign sint     = frame_end;

endmodule

// File: tb/tb_ste_dma_snd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ste_dma_snd_ctrl
//
// Self-checking bench for ste_dma_snd_ctrl. Each test queues the word
// addresses it expects to be fetched. A negedge monitor pops and compares them
// at every sload_n falling edge. The monitor also checks the strobe length and
// counts sint pulses.
// -----------------------------------------------------------------------------
module tb_ste_dma_snd_ctrl;

    localparam int unsigned SloadLen = 4;

    logic        clk32 = 1'b0;
    logic        reset;
    logic        cs, rw;
    logic [4:0]  a;
    logic [15:0] din, dout;
    logic        slot, sreq;
    logic        sload_n, sdma_act, sactive, sint;
    logic [22:0] saddr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [22:0] exp_q[$];
    int          fetch_cnt = 0;
    int          sint_cnt = 0;
    bit          expect_abort = 1'b0;
    bit          slot_on = 1'b0;
    int          cyc = 0;

    ste_dma_snd_ctrl #(.SLOAD_LEN(SloadLen)) dut (
        .clk32    (clk32),
        .reset    (reset),
        .cs       (cs),
        .rw       (rw),
        .a        (a),
        .din      (din),
        .dout     (dout),
        .slot     (slot),
        .sreq     (sreq),
        .sload_n  (sload_n),
        .sdma_act (sdma_act),
        .saddr    (saddr),
        .sactive  (sactive),
        .sint     (sint)
    );

    always #5 clk32 = ~clk32;

    // Slot pulse every 20 cycles.
    initial begin
        slot = 1'b0;
        forever begin
            @(posedge clk32);
            #1;
            cyc++;
            slot = slot_on && (cyc % 20 == 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Fetch monitor / scoreboard.
    logic        prev_sload_n = 1'b1;
    logic [22:0] cur_addr = '0;
    logic [22:0] exp_addr;
    int          low_len = 0;

    always @(negedge clk32) begin
        if (sint === 1'b1) sint_cnt++;
        if (prev_sload_n && !sload_n) begin
            fetch_cnt++;
            cur_addr = saddr;
            low_len  = 1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fetch_unexpected: saddr=%h, required no fetch", saddr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (saddr !== exp_addr) begin
                    n_err++;
                    $display("FAIL fetch_addr: saddr=%h, required %h", saddr, exp_addr);
                end
            end
            n_cmp++;
            if (sdma_act !== 1'b1) begin
                n_err++;
                $display("FAIL fetch_act: sdma_act=%b, required 1", sdma_act);
            end
        end else if (!prev_sload_n && !sload_n) begin
            low_len++;
            n_cmp++;
            if (saddr !== cur_addr || sdma_act !== 1'b1) begin
                n_err++;
                $display("FAIL fetch_stable: saddr=%h act=%b, required %h act=1",
                         saddr, sdma_act, cur_addr);
            end
        end else if (!prev_sload_n && sload_n) begin
            if (!expect_abort) begin
                n_cmp++;
                if (low_len != SloadLen) begin
                    n_err++;
                    $display("FAIL sload_len: low for %0d cycles, required %0d", low_len, SloadLen);
                end
            end
            n_cmp++;
            if (sdma_act !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_release: sdma_act=%b, required 0", sdma_act);
            end
        end
        prev_sload_n = sload_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cpu_write(input logic [4:0] idx, input logic [15:0] data);
        @(posedge clk32);
        #1;
        cs = 1'b1; rw = 1'b0; a = idx; din = data;
        @(posedge clk32);
        #1;
        cs = 1'b0; rw = 1'b1; a = '0; din = '0;
    endtask

    task automatic cpu_read(input logic [4:0] idx, output logic [15:0] data);
        @(posedge clk32);
        #1;
        cs = 1'b1; rw = 1'b1; a = idx;
        @(negedge clk32);
        data = dout;
        cs = 1'b0;
    endtask

    task automatic write_addr(input logic [4:0] base, input logic [23:0] b);
        cpu_write(base, {8'h00, b[23:16]});
        cpu_write(base + 5'd1, {8'h00, b[15:8]});
        cpu_write(base + 5'd2, {8'h00, b[7:0]});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic wait_fetch(input int target, input int limit, output bit ok);
        for (int i = 0; i < limit; i++) begin
            if (fetch_cnt >= target) break;
            @(negedge clk32);
            #1;
        end
        ok = (fetch_cnt >= target);
    endtask

    task automatic wait_sint(input int target, input int limit, output bit ok);
        for (int i = 0; i < limit; i++) begin
            if (sint_cnt >= target) break;
            @(negedge clk32);
            #1;
        end
        ok = (sint_cnt >= target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] rd;
        reset = 1'b1; cs = 1'b0; rw = 1'b1; a = '0; din = '0; sreq = 1'b0;
        repeat (3) @(posedge clk32);
        #1;
        reset = 1'b0;
        @(negedge clk32);
        n_cmp++;
        if (sload_n !== 1'b1 || sdma_act !== 1'b0 || sint !== 1'b0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: sload_n=%b act=%b sint=%b sactive=%b, required 1 0 0 0",
                     sload_n, sdma_act, sint, sactive);
        end
        n_cmp++;
        if (saddr !== 23'h0) begin
            n_err++;
            $display("FAIL reset_saddr: %h, required 0", saddr);
        end
        for (int i = 0; i < 10; i++) begin
            cpu_read(5'(i), rd);
            n_cmp++;
            if (rd !== 16'h0) begin
                n_err++;
                $display("FAIL reset_reg%0d: %h, required 0000", i, rd);
            end
        end
    endtask

    task automatic test_regs();
        logic [15:0] rd;
        logic [15:0] exp_start[3];
        logic [15:0] exp_end[3];
        exp_start = '{16'h0012, 16'h0034, 16'h0056};
        exp_end   = '{16'h00AB, 16'h00CD, 16'h00EE};
        write_addr(5'd1, 24'h123457);
        write_addr(5'd7, 24'hABCDEF);
        for (int i = 0; i < 3; i++) begin
            cpu_read(5'(1 + i), rd);
            n_cmp++;
            if (rd !== exp_start[i]) begin
                n_err++;
                $display("FAIL reg_start%0d: %h, required %h", i, rd, exp_start[i]);
            end
            cpu_read(5'(7 + i), rd);
            n_cmp++;
            if (rd !== exp_end[i]) begin
                n_err++;
                $display("FAIL reg_end%0d: %h, required %h", i, rd, exp_end[i]);
            end
        end
        // Counter is read-only; unmapped indices read 0.
        cpu_write(5'd4, 16'hFFFF);
        cpu_write(5'd6, 16'hFFFF);
        cpu_write(5'd15, 16'hFFFF);
        cpu_read(5'd4, rd);
        n_cmp++;
        if (rd !== 16'h0) begin n_err++; $display("FAIL reg_cnt_ro: %h, required 0000", rd); end
        cpu_read(5'd6, rd);
        n_cmp++;
        if (rd !== 16'h0) begin n_err++; $display("FAIL reg_cnt_lo_ro: %h, required 0000", rd); end
        cpu_read(5'd15, rd);
        n_cmp++;
        if (rd !== 16'h0) begin n_err++; $display("FAIL reg_unmapped: %h, required 0000", rd); end
        cpu_write(5'd0, 16'h0002);
        cpu_read(5'd0, rd);
        n_cmp++;
        if (rd !== 16'h0002 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL reg_ctrl: %h sactive=%b, required 0002 0", rd, sactive);
        end
        cpu_write(5'd0, 16'h0000);
        // dout stays 0 without cs.
        @(posedge clk32);
        #1;
        cs = 1'b0; rw = 1'b1; a = 5'd1;
        #1;
        n_cmp++;
        if (dout !== 16'h0) begin n_err++; $display("FAIL dout_no_cs: %h, required 0000", dout); end
        a = '0;
    endtask

    task automatic test_single_shot();
        int f0, s0;
        bit ok;
        logic [15:0] rd;
        f0 = fetch_cnt; s0 = sint_cnt;
        write_addr(5'd1, 24'h010000);
        write_addr(5'd7, 24'h010004);
        exp_q.push_back(23'h008000);
        exp_q.push_back(23'h008001);
        cpu_write(5'd0, 16'h0001);
        wait_sint(s0 + 1, 200, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_sint_timeout: sint count %0d, required %0d", sint_cnt, s0 + 1); end
        wait_cycles(60);
        n_cmp++;
        if (fetch_cnt - f0 != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_fetches: %0d fetched, %0d pending, required 2 and 0",
                     fetch_cnt - f0, exp_q.size());
        end
        n_cmp++;
        if (sint_cnt - s0 != 1) begin n_err++; $display("FAIL single_sint_count: %0d, required 1", sint_cnt - s0); end
        n_cmp++;
        if (sactive !== 1'b0) begin n_err++; $display("FAIL single_sactive: %b, required 0", sactive); end
        cpu_read(5'd6, rd);
        n_cmp++;
        if (rd !== 16'h0004) begin n_err++; $display("FAIL single_cnt_lo: %h, required 0004", rd); end
    endtask

    task automatic test_loop_retarget();
        int f0, s0;
        bit ok;
        f0 = fetch_cnt; s0 = sint_cnt;
        write_addr(5'd1, 24'h010000);
        write_addr(5'd7, 24'h010004);
        exp_q.push_back(23'h008000);
        exp_q.push_back(23'h008001);
        for (int i = 0; i < 4; i++) exp_q.push_back(23'h008000 + 23'(i));
        cpu_write(5'd0, 16'h0003);
        wait_fetch(f0 + 1, 100, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL loop_first_fetch_timeout: fetches %0d, required %0d", fetch_cnt - f0, 1); end
        cpu_write(5'd9, 16'h0008);
        wait_sint(s0 + 2, 400, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL loop_sint_timeout: sint count %0d, required %0d", sint_cnt - s0, 2); end
        cpu_write(5'd0, 16'h0000);
        wait_cycles(60);
        n_cmp++;
        if (fetch_cnt - f0 != 6 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL loop_fetches: %0d fetched, %0d pending, required 6 and 0",
                     fetch_cnt - f0, exp_q.size());
        end
        n_cmp++;
        if (sint_cnt - s0 != 2 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL loop_end: sint %0d sactive %b, required 2 0", sint_cnt - s0, sactive);
        end
    endtask

    task automatic test_backpressure();
        int f0;
        bit ok;
        logic [15:0] rd;
        f0 = fetch_cnt;
        sreq = 1'b0;
        write_addr(5'd1, 24'h020000);
        write_addr(5'd7, 24'h020010);
        cpu_write(5'd0, 16'h0001);
        wait_cycles(65);
        n_cmp++;
        if (fetch_cnt != f0) begin n_err++; $display("FAIL bp_no_fetch: %0d fetches, required 0", fetch_cnt - f0); end
        cpu_read(5'd4, rd);
        n_cmp++;
        if (rd !== 16'h0002) begin n_err++; $display("FAIL bp_cnt_hi: %h, required 0002", rd); end
        cpu_read(5'd6, rd);
        n_cmp++;
        if (rd !== 16'h0000) begin n_err++; $display("FAIL bp_cnt_lo: %h, required 0000", rd); end
        exp_q.push_back(23'h010000);
        sreq = 1'b1;
        wait_fetch(f0 + 1, 25, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_resume_timeout: fetches %0d, required 1", fetch_cnt - f0); end
        cpu_write(5'd0, 16'h0000);
        wait_cycles(30);
        n_cmp++;
        if (exp_q.size() != 0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: pending %0d sactive %b, required 0 0", exp_q.size(), sactive);
        end
    endtask

    task automatic test_disable_in_load();
        int f0, s0;
        bit ok;
        logic [15:0] rd;
        f0 = fetch_cnt; s0 = sint_cnt;
        write_addr(5'd1, 24'h030000);
        write_addr(5'd7, 24'h030010);
        exp_q.push_back(23'h018000);
        cpu_write(5'd0, 16'h0001);
        wait_fetch(f0 + 1, 60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL dis_fetch_timeout: fetches %0d, required 1", fetch_cnt - f0); end
        cpu_write(5'd0, 16'h0000);   // presented during the 2nd LOAD cycle
        wait_cycles(50);
        n_cmp++;
        if (fetch_cnt - f0 != 1 || sint_cnt != s0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL dis_end: fetches %0d sint %0d sactive %b, required 1 0 0",
                     fetch_cnt - f0, sint_cnt - s0, sactive);
        end
        cpu_read(5'd6, rd);
        n_cmp++;
        if (rd !== 16'h0002) begin n_err++; $display("FAIL dis_cnt_lo: %h, required 0002", rd); end
    endtask

    task automatic test_reset_in_load();
        int f0;
        bit ok;
        logic [15:0] rd;
        f0 = fetch_cnt;
        write_addr(5'd1, 24'h040000);
        write_addr(5'd7, 24'h040010);
        exp_q.push_back(23'h020000);
        expect_abort = 1'b1;
        cpu_write(5'd0, 16'h0003);
        wait_fetch(f0 + 1, 60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rst_fetch_timeout: fetches %0d, required 1", fetch_cnt - f0); end
        @(posedge clk32);
        #1;
        @(posedge clk32);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (sload_n !== 1'b1 || sdma_act !== 1'b0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_load: sload_n=%b act=%b sactive=%b, required 1 0 0",
                     sload_n, sdma_act, sactive);
        end
        @(posedge clk32);
        #1;
        reset = 1'b0;
        wait_cycles(2);
        expect_abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_read(5'(i), rd);
            n_cmp++;
            if (rd !== 16'h0) begin
                n_err++;
                $display("FAIL rst_reg%0d: %h, required 0000", i, rd);
            end
        end
    endtask

    task automatic test_wrap_empty();
        int f0, s0;
        bit ok;
        logic s_seen[3];
        f0 = fetch_cnt; s0 = sint_cnt;
        write_addr(5'd1, 24'hFFFFFE);
        write_addr(5'd7, 24'h000002);
        exp_q.push_back(23'h7FFFFF);
        exp_q.push_back(23'h000000);
        cpu_write(5'd0, 16'h0001);
        wait_sint(s0 + 1, 150, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wrap_sint_timeout: sint %0d, required 1", sint_cnt - s0); end
        wait_cycles(30);
        n_cmp++;
        if (fetch_cnt - f0 != 2 || exp_q.size() != 0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_end: fetches %0d pending %0d sactive %b, required 2 0 0",
                     fetch_cnt - f0, exp_q.size(), sactive);
        end
        // Empty frame: start == end.
        f0 = fetch_cnt; s0 = sint_cnt;
        write_addr(5'd1, 24'h050000);
        write_addr(5'd7, 24'h050000);
        cpu_write(5'd0, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk32);
            s_seen[i] = sint;
        end
        n_cmp++;
        if (s_seen[0] !== 1'b0 || s_seen[1] !== 1'b0 || s_seen[2] !== 1'b1) begin
            n_err++;
            $display("FAIL empty_sint_timing: idle/arm/wait sint=%b%b%b, required 001",
                     s_seen[0], s_seen[1], s_seen[2]);
        end
        wait_cycles(40);
        n_cmp++;
        if (sint_cnt - s0 != 1 || fetch_cnt != f0 || sactive !== 1'b0) begin
            n_err++;
            $display("FAIL empty_end: sint %0d fetches %0d sactive %b, required 1 0 0",
                     sint_cnt - s0, fetch_cnt - f0, sactive);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        slot_on = 1'b1;
        sreq    = 1'b1;
        test_single_shot();
        test_loop_retarget();
        test_backpressure();
        test_disable_in_load();
        test_reset_in_load();
        sreq = 1'b1;
        test_wrap_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
